// File: rtl/sync_fifo_pkg.sv
// Shared types and width helpers for the sync_fifo_v2 FIFO family.
package sync_fifo_pkg;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // The count has to hold 0..DEPTH inclusive, so it needs the same width as a pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port register-array storage for sync_fifo_v2.
// SYNC_FIFO_FWFT_EN selects a combinational read port; otherwise the read port is registered.
module fifo_mem_2p #(
    parameter int DEPTH  = 8,
    parameter int DWIDTH = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem[raddr];

    wire unused_rd_ctl = ^{rst, re};
`else
    // In this mode the output register is the FIFO's dout, so it holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
`endif

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with count, almost flags, sticky error flags, flush and read-valid strobe.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DWIDTH   = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        dout,
    output logic                     dout_vld,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          wr_accept;
    logic          rd_accept;
    fifo_status_t  status;

    assign status.full         = (count == DEPTH_C);
    assign status.almost_full  = (count >= AF_C);
    assign status.empty        = (count == '0);
    assign status.almost_empty = (count <= AE_C);
    assign status.overflow     = overflow;
    assign status.underflow    = underflow;

    assign full         = status.full;
    assign almost_full  = status.almost_full;
    assign empty        = status.empty;
    assign almost_empty = status.almost_empty;

    // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
    assign rd_accept = rd_en & ~status.empty;
    assign wr_accept = wr_en & (~status.full | rd_accept);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept)
                wptr <= wptr + PW'(1);
            if (rd_accept)
                rptr <= rptr + PW'(1);
            count <= count + CW'(wr_accept) - CW'(rd_accept);
            if (wr_en && !wr_accept)
                overflow <= 1'b1;
            if (rd_en && !rd_accept)
                underflow <= 1'b1;
        end
    end

    fifo_mem_2p #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rstn),
        .we    (wr_accept & ~clr),
        .waddr (wptr[AW-1:0]),
        .wdata (din),
        .re    (rd_accept & ~clr),
        .raddr (rptr[AW-1:0]),
        .rdata (dout)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign dout_vld = ~status.empty;
`else
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)
            dout_vld <= 1'b0;
        else
            dout_vld <= rd_accept & ~clr;
    end
`endif

    // Flags come from count, so the wrap bits only matter for modulo-2*DEPTH pointer arithmetic.
    wire unused_wrap = wptr[AW] ^ rptr[AW];

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed self-checking bench for sync_fifo_v2 (DEPTH=8, DWIDTH=16, AF=6, AE=2).
// Honours SYNC_FIFO_FWFT_EN to pick the read-mode specific sequences.
module tb_sync_fifo_v2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        wr_en;
    logic [15:0] din;
    logic        rd_en;
    logic [15:0] dout;
    logic        dout_vld;
    logic        full;
    logic        almost_full;
    logic        empty;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_v2 #(
        .DEPTH    (8),
        .DWIDTH   (16),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (clr),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock and settle just past the edge, so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r, input logic c);
        wr_en = w;
        din   = d;
        rd_en = r;
        clr   = c;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        rstn  = 1'b1;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        tick();
        tick();

        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_ae", 32'(almost_empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_af", 32'(almost_full), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_udf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_vld", 32'(dout_vld), 32'd0);
`else
        checkOutput("rst_vld", 32'(dout_vld), 32'd0);
`endif
        rstn = 1'b0;
        tick();

        // Fill to full, watching almost_full and full thresholds.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 16'(k), 1'b0, 1'b0);
            checkOutput("t1_count", 32'(count), 32'(k));
            checkOutput("t1_af", 32'(almost_full), (k >= 6) ? 32'd1 : 32'd0);
            checkOutput("t1_full", 32'(full), (k == 8) ? 32'd1 : 32'd0);
            checkOutput("t1_ae", 32'(almost_empty), (k <= 2) ? 32'd1 : 32'd0);
        end
        checkOutput("t1_ovf0", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("t1_ovf1", 32'(overflow), 32'd1);
        checkOutput("t1_count9", 32'(count), 32'd8);

`ifndef SYNC_FIFO_FWFT_EN
        // Drain in order; DEAD must not have overwritten anything.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
            checkOutput("t2_dout", 32'(dout), 32'(k));
            checkOutput("t2_vld", 32'(dout_vld), 32'd1);
            checkOutput("t2_count", 32'(count), 32'(8 - k));
        end
        tick();
        checkOutput("t2_vld_drop", 32'(dout_vld), 32'd0);
        checkOutput("t2_empty", 32'(empty), 32'd1);
        checkOutput("t2_ae", 32'(almost_empty), 32'd1);
        checkOutput("t2_udf0", 32'(underflow), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t2_udf1", 32'(underflow), 32'd1);
        checkOutput("t2_hold", 32'(dout), 32'h0008);
        checkOutput("t2_vld_rej", 32'(dout_vld), 32'd0);
        checkOutput("t2_ovf_sticky", 32'(overflow), 32'd1);

        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t3_clr_ovf", 32'(overflow), 32'd0);
        checkOutput("t3_clr_udf", 32'(underflow), 32'd0);

        // Three laps of fill, simultaneous read/write at full, then drain.
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < 8; i++)
                applyStimulus(1'b1, 16'(lap * 16 + i + 1), 1'b0, 1'b0);
            checkOutput("t3_full", 32'(full), 32'd1);
            applyStimulus(1'b1, 16'(16'h00AA + lap), 1'b1, 1'b0);
            checkOutput("t3_rw_count", 32'(count), 32'd8);
            checkOutput("t3_rw_ovf", 32'(overflow), 32'd0);
            checkOutput("t3_rw_dout", 32'(dout), 32'(lap * 16 + 1));
            for (int i = 2; i <= 8; i++) begin
                applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
                checkOutput("t3_dout", 32'(dout), 32'(lap * 16 + i));
            end
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
            checkOutput("t3_last", 32'(dout), 32'(16'h00AA + lap));
            checkOutput("t3_empty", 32'(empty), 32'd1);
        end

        // Simultaneous read/write on empty: write lands, read is rejected.
        applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0);
        checkOutput("t4_count", 32'(count), 32'd1);
        checkOutput("t4_udf", 32'(underflow), 32'd1);
        checkOutput("t4_vld", 32'(dout_vld), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t4_dout", 32'(dout), 32'h0055);
        checkOutput("t4_vld2", 32'(dout_vld), 32'd1);
`endif

        // Flush with a competing write: flush wins and dout is untouched.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        checkOutput("t5_count5", 32'(count), 32'd5);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b1);
        checkOutput("t5_clr_count", 32'(count), 32'd0);
        checkOutput("t5_clr_empty", 32'(empty), 32'd1);
        checkOutput("t5_clr_ovf", 32'(overflow), 32'd0);
        checkOutput("t5_clr_udf", 32'(underflow), 32'd0);
        checkOutput("t5_clr_vld", 32'(dout_vld), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        checkOutput("t5_clr_hold", 32'(dout), 32'h0055);
`endif
        tick();
        checkOutput("t5_clr_ignored", 32'(count), 32'd0);

        // Reset in the middle of a burst must act without a clock edge.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        wr_en = 1'b1;
        din   = 16'h0203;
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        checkOutput("t5_pre_rst", 32'(count), 32'd4);
        rstn = 1'b1;
        #1;
        checkOutput("t5_rst_count", 32'(count), 32'd0);
        checkOutput("t5_rst_empty", 32'(empty), 32'd1);
        checkOutput("t5_rst_full", 32'(full), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        checkOutput("t5_rst_dout", 32'(dout), 32'd0);
`endif
        checkOutput("t5_rst_vld", 32'(dout_vld), 32'd0);
        tick();
        rstn = 1'b0;
        tick();
        applyStimulus(1'b1, 16'h0077, 1'b0, 1'b0);
        checkOutput("t5_fresh_count", 32'(count), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t5_fresh_dout", 32'(dout), 32'h0077);
`else
        checkOutput("t5_fresh_dout", 32'(dout), 32'h0077);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
`endif
        checkOutput("t5_fresh_empty", 32'(empty), 32'd1);

`ifdef SYNC_FIFO_FWFT_EN
        // Fall-through: the head word is visible without a read request.
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkOutput("t6_dout", 32'(dout), 32'h1234);
        checkOutput("t6_vld", 32'(dout_vld), 32'd1);
        applyStimulus(1'b1, 16'h5678, 1'b0, 1'b0);
        checkOutput("t6_head_kept", 32'(dout), 32'h1234);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t6_next", 32'(dout), 32'h5678);
        checkOutput("t6_vld_next", 32'(dout_vld), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t6_empty", 32'(empty), 32'd1);
        checkOutput("t6_vld_drop", 32'(dout_vld), 32'd0);
        checkOutput("t6_udf", 32'(underflow), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
